// File: rtl/pipe_hazard_unit_if.sv
// ID-stage hazard bundle between the pipeline control and the hazard unit.
// The master drives the ID/EX status. The slave returns the PC and pipeline-register controls.
// Combinational path only; no storage lives in the interface.
interface pipe_hazard_unit_if #(
    parameter int AW = 5,
    parameter int SW = 2
);
    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_wr_en;
    logic [AW-1:0] id_wr_addr;
    logic          id_is_load;
    logic          id_is_md;
    logic          id_uses_hilo;
    logic          ex_redirect;
    logic          mem_wait;
    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_bubble;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
    logic          md_busy;
    logic [31:0]   stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
               id_is_load, id_is_md, id_uses_hilo, ex_redirect, mem_wait,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               md_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
               id_is_load, id_is_md, id_uses_hilo, ex_redirect, mem_wait,
        output pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b,
               md_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and stall control for the 5-stage pipeline, built on a private destination scoreboard.
// Controls are combinational from the scoreboard and ID inputs. The scoreboard and counters update on each clock edge.
// Backpressure: mem_wait freezes everything except the MD countdown. A redirect overrides any hazard stall.
module pipe_hazard_unit #(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4,
    parameter int SW       = $clog2(DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_unit_if.slave hz
);
    localparam int MCW = $clog2(MD_LAT + 1);

    logic [DEPTH:1]  sb_v_q, sb_we_q, sb_ld_q;
    logic [AW-1:0]   sb_addr_q [1:DEPTH];
    logic [MCW-1:0]  md_cnt_q, md_cnt_d;
    logic [31:0]     stall_cnt_q;

    logic [SW-1:0]   fwd_a_c, fwd_b_c;
    logic            hit_a, hit_b, lu_a, lu_b;
    logic            md_busy_c, lu_stall, md_stall, hz_stall;
    logic            pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

    // The youngest matching stage wins. Older matches cannot forward or stall once it is found.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        lu_a    = 1'b0;
        lu_b    = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!hit_a && hz.id_use_rs && hz.id_rs != '0 && sb_v_q[k] && sb_we_q[k]
                && sb_addr_q[k] == hz.id_rs) begin
                hit_a   = 1'b1;
                fwd_a_c = SW'(k);
                lu_a    = sb_ld_q[k] && (k <= LOAD_LAT);
            end
            if (!hit_b && hz.id_use_rt && hz.id_rt != '0 && sb_v_q[k] && sb_we_q[k]
                && sb_addr_q[k] == hz.id_rt) begin
                hit_b   = 1'b1;
                fwd_b_c = SW'(k);
                lu_b    = sb_ld_q[k] && (k <= LOAD_LAT);
            end
        end
    end

    assign md_busy_c = (md_cnt_q != '0);
    assign lu_stall  = hz.id_valid && (lu_a || lu_b);
    assign md_stall  = hz.id_valid && md_busy_c && (hz.id_uses_hilo || hz.id_is_md);
    assign hz_stall  = (lu_stall || md_stall) && !hz.ex_redirect && !hz.mem_wait;

    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        if (hz.mem_wait) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
        end else if (hz.ex_redirect) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
        end else if (hz_stall) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
        end
    end

    // The MD countdown keeps running through mem_wait. Only a cleanly issued MD op reloads it.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.id_valid && hz.id_is_md && !hz_stall && !hz.ex_redirect && !hz.mem_wait)
            md_cnt_d = MCW'(MD_LAT);
        else if (md_busy_c)
            md_cnt_d = md_cnt_q - MCW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_v_q      <= '0;
            sb_we_q     <= '0;
            sb_ld_q     <= '0;
            for (int k = 1; k <= DEPTH; k++) sb_addr_q[k] <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
            if (hz_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (!hz.mem_wait) begin
                for (int k = DEPTH; k >= 2; k--) begin
                    sb_v_q[k]    <= sb_v_q[k-1];
                    sb_we_q[k]   <= sb_we_q[k-1];
                    sb_ld_q[k]   <= sb_ld_q[k-1];
                    sb_addr_q[k] <= sb_addr_q[k-1];
                end
                sb_v_q[1]    <= hz.id_valid   && !idex_bubble_c;
                sb_we_q[1]   <= hz.id_wr_en   && !idex_bubble_c;
                sb_ld_q[1]   <= hz.id_is_load && !idex_bubble_c;
                sb_addr_q[1] <= idex_bubble_c ? '0 : hz.id_wr_addr;
            end
        end
    end

    assign hz.pc_write    = pc_write_c;
    assign hz.ifid_write  = ifid_write_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.fwd_a       = fwd_a_c;
    assign hz.fwd_b       = fwd_b_c;
    assign hz.md_busy     = md_busy_c;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule
